// File: rtl/imem_debug_loader_if.sv
// rtl/imem_debug_loader_if.sv - host byte link and instruction RAM port b bundle for the debug loader
interface imem_debug_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] ram_addr;
   logic [31:0] ram_din;
   logic        ram_we;
   logic [31:0] ram_dout;

   modport master (
      output rx_data, rx_valid, tx_ready, ram_dout,
      input  rx_ready, tx_data, tx_valid, ram_addr, ram_din, ram_we
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready, ram_dout,
      output rx_ready, tx_data, tx_valid, ram_addr, ram_din, ram_we
   );
endinterface

// File: rtl/imem_debug_loader.sv
// rtl/imem_debug_loader.sv - byte-stream block write/read engine on instruction RAM port b
// Header: opcode, 4 address bytes, 2 count bytes (all MSB-first), then N data words.
module imem_debug_loader #(
   parameter logic [7:0] CMD_WRITE = 8'h57,
   parameter logic [7:0] CMD_READ  = 8'h52
) (
   input  logic             clk,
   input  logic             rst,
   imem_debug_loader_if.slave bus,
   output logic             busy,
   output logic             cpu_hold,
   output logic             cmd_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_WR_DATA, S_WR_PULSE,
      S_RD_ADDR, S_RD_CAP, S_RD_TX, S_DONE
   } state_e;

   state_e      state_q;
   logic [31:0] addr_q;
   logic [31:0] din_q;
   logic [31:0] tx_sh_q;
   logic [15:0] cnt_q;
   logic [1:0]  byte_q;
   logic        is_rd_q;
   logic        ram_we_q;
   logic        tx_valid_q;
   logic        busy_q;
   logic        cmd_err_q;

   logic        accept_st;
   logic        rx_fire;
   logic        tx_fire;
   logic [15:0] cnt_shift;

   // Byte acceptance is gated by rst so nothing is consumed during the reset cycle.
   assign accept_st = (state_q == S_IDLE) || (state_q == S_HDR_ADDR) ||
                      (state_q == S_HDR_CNT) || (state_q == S_WR_DATA);
   assign bus.rx_ready = accept_st & ~rst;
   assign rx_fire   = bus.rx_valid & bus.rx_ready;
   assign tx_fire   = tx_valid_q & bus.tx_ready;
   assign cnt_shift = {cnt_q[7:0], bus.rx_data};

   assign bus.tx_data  = tx_sh_q[31:24];
   assign bus.tx_valid = tx_valid_q;
   assign bus.ram_addr = addr_q;
   assign bus.ram_din  = din_q;
   assign bus.ram_we   = ram_we_q;
   assign busy         = busy_q;
   assign cpu_hold     = busy_q;
   assign cmd_err      = cmd_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         din_q      <= '0;
         tx_sh_q    <= '0;
         cnt_q      <= '0;
         byte_q     <= '0;
         is_rd_q    <= 1'b0;
         ram_we_q   <= 1'b0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rx_fire) begin
                  if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
                     is_rd_q <= (bus.rx_data == CMD_READ);
                     byte_q  <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_HDR_ADDR;
                  end else begin
                     cmd_err_q <= 1'b1;
                  end
               end
            end
            S_HDR_ADDR: begin
               if (rx_fire) begin
                  byte_q <= byte_q + 2'd1;
                  if (byte_q == 2'd3) begin
                     addr_q  <= {addr_q[23:0], bus.rx_data[7:2], 2'b00};
                     state_q <= S_HDR_CNT;
                  end else begin
                     addr_q <= {addr_q[23:0], bus.rx_data};
                  end
               end
            end
            S_HDR_CNT: begin
               if (rx_fire) begin
                  cnt_q  <= cnt_shift;
                  byte_q <= byte_q + 2'd1;
                  if (byte_q == 2'd1) begin
                     byte_q <= '0;
                     if (cnt_shift == 16'd0)
                        state_q <= S_DONE;
                     else if (is_rd_q)
                        state_q <= S_RD_ADDR;
                     else
                        state_q <= S_WR_DATA;
                  end
               end
            end
            S_WR_DATA: begin
               if (rx_fire) begin
                  din_q  <= {din_q[23:0], bus.rx_data};
                  byte_q <= byte_q + 2'd1;
                  if (byte_q == 2'd3) begin
                     ram_we_q <= 1'b1;
                     state_q  <= S_WR_PULSE;
                  end
               end
            end
            S_WR_PULSE: begin
               ram_we_q <= 1'b0;
               addr_q   <= addr_q + 32'd4;
               cnt_q    <= cnt_q - 16'd1;
               state_q  <= (cnt_q == 16'd1) ? S_DONE : S_WR_DATA;
            end
            S_RD_ADDR: begin
               state_q <= S_RD_CAP;
            end
            // RAM output for the address presented in RD_ADDR is valid here.
            S_RD_CAP: begin
               tx_sh_q    <= bus.ram_dout;
               tx_valid_q <= 1'b1;
               byte_q     <= '0;
               state_q    <= S_RD_TX;
            end
            S_RD_TX: begin
               if (tx_fire) begin
                  tx_sh_q <= {tx_sh_q[23:0], 8'h00};
                  byte_q  <= byte_q + 2'd1;
                  if (byte_q == 2'd3) begin
                     tx_valid_q <= 1'b0;
                     addr_q     <= addr_q + 32'd4;
                     cnt_q      <= cnt_q - 16'd1;
                     state_q    <= (cnt_q == 16'd1) ? S_DONE : S_RD_ADDR;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
